l1d_ram_arbiter: RTL and testbench
==================================

L1D_RAM_ARBITER -- requirements
Module: l1d_ram_arbiter

Interface
REQ-001 The block SHALL have these parameters: NUM_REQ, default 4, number of requesters; WIDTH, default 8, data width; DEPTH, default 8, RAM entries, a power of two, at least 2.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 rd_req_vld  input  NUM_REQ  per-requester read request.
REQ-005 rd_req_addr  input  NUM_REQ x clog2(DEPTH)  per-requester read address.
REQ-006 rd_req_rdy  output  NUM_REQ  one-hot read grant; the read transfers when vld and rdy are both high.
REQ-007 wr_req_vld, wr_req_addr, wr_req_data, wr_req_rdy  in/in/in/out  NUM_REQ, NUM_REQ x clog2(DEPTH), NUM_REQ x WIDTH, NUM_REQ  write channel with the same handshake.
REQ-008 rd_resp_vld  output  NUM_REQ  one-hot; marks read data returned to that requester.
REQ-009 rd_resp_data  output  WIDTH  read data, shared by all requesters.
REQ-010 init_req  input  1  pulse that starts a zeroing sweep of the RAM.
REQ-011 init_busy  output  1  high while the sweep is running.
REQ-012 ram_ra, ram_re, ram_rd  out/out/in  clog2(DEPTH), 1, WIDTH  read port of pseudo_dual_ram.
REQ-013 ram_wa, ram_we, ram_wd  out/out/out  clog2(DEPTH), 1, WIDTH  write port of pseudo_dual_ram.

Function
REQ-014 Reads and writes SHALL be arbitrated independently; each channel grants at most one requester per cycle.
REQ-015 Grants SHALL be combinational from vld and the arbiter state; rdy SHALL never assert for a requester whose vld is low.
REQ-016 On a read grant in cycle T, ram_re=1 and ram_ra=the granted address in cycle T.
REQ-017 For a read granted in cycle T, rd_resp_vld SHALL be high for that requester in cycle T+1, with rd_resp_data=ram_rd; read latency is 1 cycle.
REQ-018 The granted requester index SHALL be registered for the response; back-to-back grants SHALL give back-to-back responses.
REQ-019 On a write grant, ram_we=1 and ram_wa/ram_wd SHALL carry the granted address and data in the same cycle.
REQ-020 When no grant is made: ram_re=0, ram_we=0, and address/data outputs=0.
REQ-021 The FSM SHALL have two states, IDLE and INIT. IDLE->INIT on init_req=1. INIT->IDLE after the write to address DEPTH-1.
REQ-022 In INIT the block SHALL drive ram_we=1, ram_wd=0 and ram_wa=counter, the counter running 0..DEPTH-1 one per cycle, so the sweep lasts exactly DEPTH cycles.
REQ-023 In INIT all rd_req_rdy and wr_req_rdy SHALL be 0, and init_busy=1.
REQ-024 Read responses for grants made in the cycle before INIT SHALL still be delivered.
REQ-025 init_req while already in INIT SHALL be ignored; the sweep SHALL NOT restart.
REQ-026 init_req in IDLE SHALL take priority over pending requests in that cycle: no grants are made.
REQ-027 A read and a write to the same address granted in the same cycle SHALL both be forwarded; the RAM's bypass returns the new data.

Reset
REQ-028 While rst=1, all outputs SHALL be 0, the FSM SHALL be in IDLE, the counter 0, the round-robin pointers 0, and the response pipeline cleared.
REQ-029 rst asserted mid-sweep or mid-response SHALL abort it; no rd_resp_vld SHALL appear after reset deassertion without a new grant.

Configuration
REQ-030 With L1D_RAM_ARB_RR_EN defined, each channel SHALL use round-robin arbitration: after a grant to i, the highest priority moves to i+1 mod NUM_REQ, and the pointer is held when there is no grant.
REQ-031 Without L1D_RAM_ARB_RR_EN, each channel SHALL use fixed priority, lowest index first, with no pointer state.

Structure
REQ-032 The package l1d_ram_arb_pkg SHALL hold the FSM state enum (IDLE, INIT) and a function that derives the index width.
REQ-033 One sub-module, l1d_rr_arbiter (vld vector in, one-hot grant out, pointer update), SHALL be instantiated twice, once for read and once for write.

Verification
REQ-034 The bench SHALL cover these directed scenarios, with the RR macro defined and NUM_REQ=4:
- All four rd_req_vld held high for 8 cycles -> grants 0,1,2,3,0,1,2,3, and each rd_resp_vld one cycle after its grant.
- Write addr 5 data 0xA5 from requester 2, then read addr 5 from requester 0 in the next cycle -> rd_resp_data=0xA5 with rd_resp_vld[0].
- Write and read of addr 3 in the same cycle, data 0x3C -> the response is 0x3C.
- init_req with DEPTH=8 -> init_busy high for exactly 8 cycles, ram_wa=0..7, rdy=0 throughout, and a subsequent read of any address returns 0.
- rst pulsed in sweep cycle 3 -> all outputs 0 immediately, IDLE after release, and no stray response.
- Without the macro, all vld held high -> requester 0 is granted every cycle.

Source files
------------

// File: rtl/l1d_ram_arb_pkg.sv
// Shared types and helpers for the L1D RAM arbiter.
package l1d_ram_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        INIT = 1'b1
    } state_t;

    // Index width for n items, never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/l1d_rr_arbiter.sv
// One-hot request arbiter: round-robin when L1D_RAM_ARB_RR_EN is defined,
// otherwise fixed priority (lowest index wins) with no pointer state.
module l1d_rr_arbiter
    import l1d_ram_arb_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] vld,
    output logic [N-1:0] gnt
);

    localparam int unsigned IW = idx_width(N);

`ifdef L1D_RAM_ARB_RR_EN
    logic [IW-1:0] ptr;
    logic [IW-1:0] gidx;

    // Search requesters starting at the pointer, wrapping around.
    always_comb begin
        logic [IW-1:0] sel;
        logic          found;
        gnt   = '0;
        gidx  = '0;
        sel   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            sel = IW'((32'(ptr) + k) % N);
            if (en && vld[sel] && !found) begin
                gnt[sel] = 1'b1;
                gidx     = sel;
                found    = 1'b1;
            end
        end
    end

    // Priority moves to the requester after the winner; held with no grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (|gnt) begin
            ptr <= (gidx == IW'(N - 1)) ? '0 : gidx + IW'(1);
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    // Isolate the lowest set request bit.
    always_comb begin
        gnt = en ? (vld & (~vld + N'(1))) : '0;
    end
`endif

endmodule

// File: rtl/l1d_ram_arbiter.sv
// Arbitrates per-requester read/write channels onto a pseudo dual-port RAM,
// with a zeroing sweep started by init_req. Optional round-robin arbitration
// is selected with L1D_RAM_ARB_RR_EN (fixed priority otherwise).
module l1d_ram_arbiter
    import l1d_ram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  rd_req_vld,
    input  logic [NUM_REQ*idx_width(DEPTH)-1:0] rd_req_addr,
    output logic [NUM_REQ-1:0]                  rd_req_rdy,
    input  logic [NUM_REQ-1:0]                  wr_req_vld,
    input  logic [NUM_REQ*idx_width(DEPTH)-1:0] wr_req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]            wr_req_data,
    output logic [NUM_REQ-1:0]                  wr_req_rdy,
    output logic [NUM_REQ-1:0]                  rd_resp_vld,
    output logic [WIDTH-1:0]                    rd_resp_data,
    input  logic                                init_req,
    output logic                                init_busy,
    output logic [idx_width(DEPTH)-1:0]         ram_ra,
    output logic                                ram_re,
    input  logic [WIDTH-1:0]                    ram_rd,
    output logic [idx_width(DEPTH)-1:0]         ram_wa,
    output logic                                ram_we,
    output logic [WIDTH-1:0]                    ram_wd
);

    localparam int unsigned AW = idx_width(DEPTH);

    state_t               state;
    state_t               state_nxt;
    logic [AW-1:0]        cnt;
    logic                 grant_en;
    logic [NUM_REQ-1:0]   rd_gnt;
    logic [NUM_REQ-1:0]   wr_gnt;
    logic [NUM_REQ-1:0]   resp_q;

    // Grants only in IDLE, and a same-cycle init_req blocks them.
    assign grant_en = (state == IDLE) && !init_req && !rst;

    l1d_rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
        .clk (clk),
        .rst (rst),
        .en  (grant_en),
        .vld (rd_req_vld),
        .gnt (rd_gnt)
    );

    l1d_rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
        .clk (clk),
        .rst (rst),
        .en  (grant_en),
        .vld (wr_req_vld),
        .gnt (wr_gnt)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: sweep ends after writing the last address.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (init_req) state_nxt = INIT;
            INIT:    if (cnt == AW'(DEPTH - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Sweep address counter, parked at zero outside INIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == INIT) begin
            cnt <= cnt + AW'(1);
        end else begin
            cnt <= '0;
        end
    end

    // Remember who was granted a read so the next-cycle data is routed back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_q <= '0;
        end else begin
            resp_q <= rd_gnt;
        end
    end

    // Mux the granted request onto the RAM ports; the sweep owns the write port.
    always_comb begin
        ram_re = 1'b0;
        ram_ra = '0;
        ram_we = 1'b0;
        ram_wa = '0;
        ram_wd = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (rd_gnt[i]) begin
                ram_re = 1'b1;
                ram_ra = rd_req_addr[i*AW +: AW];
            end
            if (wr_gnt[i]) begin
                ram_we = 1'b1;
                ram_wa = wr_req_addr[i*AW +: AW];
                ram_wd = wr_req_data[i*WIDTH +: WIDTH];
            end
        end
        if (state == INIT) begin
            ram_we = 1'b1;
            ram_wa = cnt;
            ram_wd = '0;
        end
    end

    assign rd_req_rdy   = rd_gnt;
    assign wr_req_rdy   = wr_gnt;
    assign init_busy    = (state == INIT);
    assign rd_resp_vld  = resp_q;
    assign rd_resp_data = (|resp_q) ? ram_rd : '0;

endmodule

// File: tb/tb_l1d_ram_arbiter.sv
// Self-checking bench for l1d_ram_arbiter (NUM_REQ=4, WIDTH=8, DEPTH=8)
// with a behavioural RAM and a transaction-level reference model.
module tb_l1d_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  rd_req_vld;
    logic [11:0] rd_req_addr;
    logic [3:0]  rd_req_rdy;
    logic [3:0]  wr_req_vld;
    logic [11:0] wr_req_addr;
    logic [31:0] wr_req_data;
    logic [3:0]  wr_req_rdy;
    logic [3:0]  rd_resp_vld;
    logic [7:0]  rd_resp_data;
    logic        init_req;
    logic        init_busy;
    logic [2:0]  ram_ra;
    logic        ram_re;
    logic [7:0]  ram_rd;
    logic [2:0]  ram_wa;
    logic        ram_we;
    logic [7:0]  ram_wd;

    int n_vec = 0;
    int n_err = 0;

    l1d_ram_arbiter #(.NUM_REQ(4), .WIDTH(8), .DEPTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .rd_req_vld   (rd_req_vld),
        .rd_req_addr  (rd_req_addr),
        .rd_req_rdy   (rd_req_rdy),
        .wr_req_vld   (wr_req_vld),
        .wr_req_addr  (wr_req_addr),
        .wr_req_data  (wr_req_data),
        .wr_req_rdy   (wr_req_rdy),
        .rd_resp_vld  (rd_resp_vld),
        .rd_resp_data (rd_resp_data),
        .init_req     (init_req),
        .init_busy    (init_busy),
        .ram_ra       (ram_ra),
        .ram_re       (ram_re),
        .ram_rd       (ram_rd),
        .ram_wa       (ram_wa),
        .ram_we       (ram_we),
        .ram_wd       (ram_wd)
    );

    always #5 clk = ~clk;

    // Behavioural pseudo dual-port RAM: 1-cycle read, write-to-read bypass.
    logic [7:0] ram_mem [8];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_wa] <= ram_wd;
        if (ram_re) ram_rd <= (ram_we && ram_wa == ram_ra) ? ram_wd : ram_mem[ram_ra];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    bit         m_busy;
    int         m_cnt;
    logic [7:0] m_mem [8];
    logic [3:0] m_resp;
    logic [7:0] m_resp_data;
`ifdef L1D_RAM_ARB_RR_EN
    int         m_rd_ptr;
    int         m_wr_ptr;
`endif

    int         e_rg, e_wg;
    logic [3:0] e_rd_rdy, e_wr_rdy;
    logic       e_re, e_we;
    logic [2:0] e_ra, e_wa;
    logic [7:0] e_wd;

    function automatic int pick(input logic [3:0] v, input int start);
        for (int k = 0; k < 4; k++) begin
            if (v[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_cnt  = 0;
        m_resp = 4'b0;
`ifdef L1D_RAM_ARB_RR_EN
        m_rd_ptr = 0;
        m_wr_ptr = 0;
`endif
    endtask

    task automatic model_eval();
        bit allow;
        int rp, wp;
        allow = !m_busy && !init_req;
`ifdef L1D_RAM_ARB_RR_EN
        rp = m_rd_ptr;
        wp = m_wr_ptr;
`else
        rp = 0;
        wp = 0;
`endif
        e_rg = allow ? pick(rd_req_vld, rp) : -1;
        e_wg = allow ? pick(wr_req_vld, wp) : -1;
        e_rd_rdy = 4'b0; e_wr_rdy = 4'b0;
        e_re = 1'b0; e_ra = 3'd0; e_we = 1'b0; e_wa = 3'd0; e_wd = 8'd0;
        if (e_rg >= 0) begin
            e_rd_rdy = 4'(1 << e_rg);
            e_re = 1'b1;
            e_ra = rd_req_addr[e_rg*3 +: 3];
        end
        if (e_wg >= 0) begin
            e_wr_rdy = 4'(1 << e_wg);
            e_we = 1'b1;
            e_wa = wr_req_addr[e_wg*3 +: 3];
            e_wd = wr_req_data[e_wg*8 +: 8];
        end
        if (m_busy) begin
            e_we = 1'b1;
            e_wa = 3'(m_cnt);
            e_wd = 8'd0;
        end
    endtask

    task automatic model_clock();
        model_eval();
        if (e_rg >= 0) begin
            m_resp      = 4'(1 << e_rg);
            m_resp_data = (e_we && e_wa == e_ra) ? e_wd : m_mem[e_ra];
        end else begin
            m_resp = 4'b0;
        end
        if (e_we) m_mem[e_wa] = e_wd;
`ifdef L1D_RAM_ARB_RR_EN
        if (e_rg >= 0) m_rd_ptr = (e_rg + 1) % 4;
        if (e_wg >= 0) m_wr_ptr = (e_wg + 1) % 4;
`endif
        if (m_busy) begin
            if (m_cnt == 7) begin m_busy = 1'b0; m_cnt = 0; end
            else m_cnt++;
        end else if (init_req) begin
            m_busy = 1'b1;
            m_cnt  = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_clock();
    endtask

    task automatic idle_inputs();
        rd_req_vld = 4'b0; rd_req_addr = 12'b0;
        wr_req_vld = 4'b0; wr_req_addr = 12'b0; wr_req_data = 32'b0;
        init_req = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [28:0] act;
        rd_req_vld = 4'($urandom); rd_req_addr = 12'($urandom);
        wr_req_vld = 4'($urandom); wr_req_addr = 12'($urandom);
        wr_req_data = $urandom; init_req = 1'b1;
        #3;
        for (int r = 0; r < 2; r++) begin
            act = {rd_req_rdy, wr_req_rdy, ram_re, ram_ra, ram_we, ram_wa, ram_wd, init_busy, rd_resp_vld};
            n_vec++;
            if (act !== 29'h0) begin n_err++; $display("FAIL reset_outputs[%0d]: got %h want 0", r, act); end
            n_vec++;
            if (rd_resp_data !== 8'h0) begin n_err++; $display("FAIL reset_data[%0d]: got %h want 0", r, rd_resp_data); end
            repeat (2) @(posedge clk);
            #1;
        end
        idle_inputs();
        rst = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if (init_busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy: got %b want 0", init_busy); end
    endtask

    task automatic test_init();
        idle_inputs();
        rd_req_vld = 4'b0100; rd_req_addr = {3'd0, 3'd5, 3'd0, 3'd0};
        #1;
        n_vec++;
        if (rd_req_rdy !== 4'b0100) begin n_err++; $display("FAIL init_pre_grant: got %b want 0100", rd_req_rdy); end
        tick();
        rd_req_vld = 4'hF; wr_req_vld = 4'hF; wr_req_data = $urandom; init_req = 1'b1;
        #1;
        n_vec++;
        if ({rd_req_rdy, wr_req_rdy, ram_re, ram_we, init_busy} !== 11'b0) begin
            n_err++; $display("FAIL init_req_priority: got %b want 0", {rd_req_rdy, wr_req_rdy, ram_re, ram_we, init_busy});
        end
        n_vec++;
        if (rd_resp_vld !== 4'b0100) begin n_err++; $display("FAIL init_pending_resp: got %b want 0100", rd_resp_vld); end
        tick();
        for (int k = 0; k < 8; k++) begin
            init_req = (k == 3);
            #1;
            n_vec++;
            if ({init_busy, rd_req_rdy, wr_req_rdy, ram_re, ram_we, ram_wa, ram_wd} !== {1'b1, 8'b0, 1'b0, 1'b1, 3'(k), 8'h00}) begin
                n_err++;
                $display("FAIL init_sweep[%0d]: busy=%b rdy=%b/%b re=%b we=%b wa=%0d wd=%h want busy=1 rdy=0 re=0 we=1 wa=%0d wd=0",
                         k, init_busy, rd_req_rdy, wr_req_rdy, ram_re, ram_we, ram_wa, ram_wd, k);
            end
            tick();
        end
        idle_inputs();
        #1;
        n_vec++;
        if (init_busy !== 1'b0) begin n_err++; $display("FAIL init_done: busy got %b want 0", init_busy); end
        for (int a = 0; a <= 8; a++) begin
            rd_req_vld  = (a < 8) ? 4'b0001 : 4'b0000;
            rd_req_addr = {9'd0, 3'(a)};
            #1;
            if (a > 0) begin
                n_vec++;
                if (rd_resp_vld !== 4'b0001 || rd_resp_data !== 8'h00) begin
                    n_err++; $display("FAIL init_readback[%0d]: vld=%b data=%h want 0001/00", a - 1, rd_resp_vld, rd_resp_data);
                end
            end
            tick();
        end
    endtask

    task automatic test_rr_reads();
        int exp_g, prev_g;
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        prev_g = 0;
        for (int c = 0; c <= 8; c++) begin
            rd_req_vld  = (c < 8) ? 4'hF : 4'h0;
            rd_req_addr = 12'($urandom);
`ifdef L1D_RAM_ARB_RR_EN
            exp_g = c % 4;
`else
            exp_g = 0;
`endif
            #1;
            model_eval();
            if (c < 8) begin
                n_vec++;
                if (rd_req_rdy !== 4'(1 << exp_g) || ram_ra !== rd_req_addr[exp_g*3 +: 3] || ram_re !== 1'b1) begin
                    n_err++; $display("FAIL rr_grant[%0d]: rdy=%b ra=%0d re=%b want rdy=%b ra=%0d re=1", c, rd_req_rdy, ram_ra, ram_re,
                                      4'(1 << exp_g), rd_req_addr[exp_g*3 +: 3]);
                end
            end
            if (c > 0) begin
                n_vec++;
                if (rd_resp_vld !== 4'(1 << prev_g) || rd_resp_data !== m_resp_data) begin
                    n_err++; $display("FAIL rr_resp[%0d]: vld=%b data=%h want %b/%h", c, rd_resp_vld, rd_resp_data, 4'(1 << prev_g), m_resp_data);
                end
            end
            prev_g = exp_g;
            tick();
        end
    endtask

    task automatic test_write_read();
        idle_inputs();
        wr_req_vld = 4'b0100; wr_req_addr = {3'd0, 3'd5, 3'd0, 3'd0}; wr_req_data = 32'h00A5_0000;
        #1;
        n_vec++;
        if ({wr_req_rdy, ram_we, ram_wa, ram_wd} !== {4'b0100, 1'b1, 3'd5, 8'hA5}) begin
            n_err++; $display("FAIL wr_grant: rdy=%b we=%b wa=%0d wd=%h want 0100/1/5/a5", wr_req_rdy, ram_we, ram_wa, ram_wd);
        end
        tick();
        idle_inputs();
        rd_req_vld = 4'b0001; rd_req_addr = {9'd0, 3'd5};
        #1;
        tick();
        idle_inputs();
        #1;
        n_vec++;
        if (rd_resp_vld !== 4'b0001 || rd_resp_data !== 8'hA5) begin
            n_err++; $display("FAIL wr_then_rd: vld=%b data=%h want 0001/a5", rd_resp_vld, rd_resp_data);
        end
    endtask

    task automatic test_same_cycle();
        idle_inputs();
        rd_req_vld = 4'b0010; rd_req_addr = {6'd0, 3'd3, 3'd0};
        wr_req_vld = 4'b1000; wr_req_addr = {3'd3, 9'd0}; wr_req_data = 32'h3C00_0000;
        #1;
        n_vec++;
        if ({ram_re, ram_ra, ram_we, ram_wa, ram_wd} !== {1'b1, 3'd3, 1'b1, 3'd3, 8'h3C}) begin
            n_err++; $display("FAIL same_cycle_ports: re=%b ra=%0d we=%b wa=%0d wd=%h want 1/3/1/3/3c", ram_re, ram_ra, ram_we, ram_wa, ram_wd);
        end
        tick();
        idle_inputs();
        #1;
        n_vec++;
        if (rd_resp_vld !== 4'b0010 || rd_resp_data !== 8'h3C) begin
            n_err++; $display("FAIL same_cycle_bypass: vld=%b data=%h want 0010/3c", rd_resp_vld, rd_resp_data);
        end
    endtask

    task automatic test_reset_mid();
        logic [28:0] act;
        idle_inputs();
        init_req = 1'b1;
        #1;
        tick();
        init_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_vec++;
            if (ram_wa !== 3'(k) || init_busy !== 1'b1) begin
                n_err++; $display("FAIL mid_sweep[%0d]: wa=%0d busy=%b want %0d/1", k, ram_wa, init_busy, k);
            end
            tick();
        end
        #1;
        rst = 1'b1;
        #1;
        act = {rd_req_rdy, wr_req_rdy, ram_re, ram_ra, ram_we, ram_wa, ram_wd, init_busy, rd_resp_vld};
        n_vec++;
        if (act !== 29'h0) begin n_err++; $display("FAIL mid_sweep_rst: got %h want 0", act); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            #1;
            n_vec++;
            if (init_busy !== 1'b0 || rd_resp_vld !== 4'b0 || ram_we !== 1'b0) begin
                n_err++; $display("FAIL post_rst_idle[%0d]: busy=%b resp=%b we=%b want 0/0/0", k, init_busy, rd_resp_vld, ram_we);
            end
            tick();
        end
        rd_req_vld = 4'b0010; rd_req_addr = {6'd0, 3'd2, 3'd0};
        #1;
        tick();
        idle_inputs();
        #1;
        n_vec++;
        if (rd_resp_vld !== 4'b0010) begin n_err++; $display("FAIL mid_resp_pre: got %b want 0010", rd_resp_vld); end
        rst = 1'b1;
        #1;
        n_vec++;
        if (rd_resp_vld !== 4'b0 || rd_resp_data !== 8'h0) begin
            n_err++; $display("FAIL mid_resp_rst: vld=%b data=%h want 0/0", rd_resp_vld, rd_resp_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            #1;
            n_vec++;
            if (rd_resp_vld !== 4'b0) begin n_err++; $display("FAIL stray_resp[%0d]: got %b want 0", k, rd_resp_vld); end
            tick();
        end
    endtask

    task automatic test_random();
        logic [28:0] act, exp;
        for (int c = 0; c < 400; c++) begin
            rd_req_vld  = 4'($urandom);
            rd_req_addr = 12'($urandom);
            wr_req_vld  = 4'($urandom);
            wr_req_addr = 12'($urandom);
            wr_req_data = $urandom;
            init_req    = ($urandom_range(0, 39) == 0);
            #1;
            model_eval();
            act = {rd_req_rdy, wr_req_rdy, ram_re, ram_ra, ram_we, ram_wa, ram_wd, init_busy, rd_resp_vld};
            exp = {e_rd_rdy, e_wr_rdy, e_re, e_ra, e_we, e_wa, e_wd, m_busy, m_resp};
            n_vec++;
            if (act !== exp) begin n_err++; $display("FAIL random_outputs[%0d]: got %h want %h", c, act, exp); end
            if (m_resp != 4'b0) begin
                n_vec++;
                if (rd_resp_data !== m_resp_data) begin
                    n_err++; $display("FAIL random_data[%0d]: got %h want %h", c, rd_resp_data, m_resp_data);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_reset();
        test_reset();
        test_init();
        test_rr_reads();
        test_write_read();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
